// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package     : aes_pkg                                                       |
// | Description : Shared types and constants for the AES inverse-cipher         |
// |               sequencer: FSM state encoding, round counts for the three     |
// |               key sizes, step indices and a state-to-step decode helper.    |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
package aes_pkg;

  // Round counts for AES-128 / AES-192 / AES-256
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // Default width of the round index (wide enough for NR_AES256)
  localparam int AES_ROUND_W = 4;

  // Datapath steps driven by the sequencer, one valid/done pair each
  localparam int NUM_STEPS      = 5;
  localparam int STEP_KEYEXP    = 0;
  localparam int STEP_ARK       = 1;
  localparam int STEP_INV_SHIFT = 2;
  localparam int STEP_INV_SUB   = 3;
  localparam int STEP_INV_MIX   = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_KEY_EXP   = 4'd1,
    ST_ARK_INIT  = 4'd2,
    ST_INV_SHIFT = 4'd3,
    ST_INV_SUB   = 4'd4,
    ST_ARK       = 4'd5,
    ST_INV_MIX   = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } state_t;

  // One-hot step owned by a state; zero for IDLE/DONE/ERR and unused codes.
  // ARK_INIT and ARK share the AddRoundKey step.
  function automatic logic [NUM_STEPS-1:0] step_of(input state_t s);
    logic [NUM_STEPS-1:0] m;
    m = '0;
    case (s)
      ST_KEY_EXP:           m[STEP_KEYEXP]    = 1'b1;
      ST_ARK_INIT, ST_ARK:  m[STEP_ARK]       = 1'b1;
      ST_INV_SHIFT:         m[STEP_INV_SHIFT] = 1'b1;
      ST_INV_SUB:           m[STEP_INV_SUB]   = 1'b1;
      ST_INV_MIX:           m[STEP_INV_MIX]   = 1'b1;
      default:              m                 = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface   : aes_inv_cipher_ctrl_if                                        |
// | Description : Host and datapath-step handshake bundle of the AES inverse-   |
// |               cipher sequencer.                                             |
// |               Host side : start, reuse_key -> ; <- busy, done, error        |
// |               Step side : <- round, valid_* ; done_* ->                     |
// |               master = sequencer, slave = host/datapath environment.        |
// |               error exists only when AES_INV_TIMEOUT_EN is defined.         |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
interface aes_inv_cipher_ctrl_if #(
  parameter int ROUND_W = 4
);
  logic               start;
  logic               reuse_key;
  logic               busy;
  logic               done;
  logic [ROUND_W-1:0] round;
  logic               valid_keyexp;
  logic               valid_ark;
  logic               valid_invshift;
  logic               valid_invsub;
  logic               valid_invmix;
  logic               done_keyexp;
  logic               done_ark;
  logic               done_invshift;
  logic               done_invsub;
  logic               done_invmix;
`ifdef AES_INV_TIMEOUT_EN
  logic               error;

  modport master (
    input  start, reuse_key,
    input  done_keyexp, done_ark, done_invshift, done_invsub, done_invmix,
    output busy, done, round, error,
    output valid_keyexp, valid_ark, valid_invshift, valid_invsub, valid_invmix
  );

  modport slave (
    output start, reuse_key,
    output done_keyexp, done_ark, done_invshift, done_invsub, done_invmix,
    input  busy, done, round, error,
    input  valid_keyexp, valid_ark, valid_invshift, valid_invsub, valid_invmix
  );
`else
  modport master (
    input  start, reuse_key,
    input  done_keyexp, done_ark, done_invshift, done_invsub, done_invmix,
    output busy, done, round,
    output valid_keyexp, valid_ark, valid_invshift, valid_invsub, valid_invmix
  );

  modport slave (
    output start, reuse_key,
    output done_keyexp, done_ark, done_invshift, done_invsub, done_invmix,
    input  busy, done, round,
    input  valid_keyexp, valid_ark, valid_invshift, valid_invsub, valid_invmix
  );
`endif
endinterface
`default_nettype wire

// File: rtl/aes_step_hs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : aes_step_hs                                                   |
// | Description : Valid register for one datapath step. set raises valid on the |
// |               edge that enters the step, clr drops it on the edge that      |
// |               leaves it (normally the edge sampling the step's done).       |
// |               With AES_INV_TIMEOUT_EN a cycle counter runs while valid is   |
// |               high and flags timeout on the TIMEOUT-th cycle.               |
// | Ports       : clk, rst (async, active-high), set, clr -> valid [, timeout]  |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module aes_step_hs #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
`ifdef AES_INV_TIMEOUT_EN
  output logic timeout,
`endif
  output logic valid
);

  logic r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (set) begin
      r_valid <= 1'b1;
    end else if (clr) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;

`ifdef AES_INV_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  // r_cnt holds the number of edges already spent in the step; the edge that
  // would make it TIMEOUT is the one that must abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (set) begin
      r_cnt <= '0;
    end else if (r_valid) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign timeout = r_valid && (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : aes_inv_cipher_ctrl                                           |
// | Description : Sequencer for AES decryption. Walks the inverse datapath      |
// |               (key expansion, AddRoundKey, InvShiftRows, InvSubBytes,       |
// |               InvMixColumns) over per-step valid/done handshakes with the   |
// |               round index counting down from NR to 0. Control only.         |
// | Ports       : clk, rst (async, active-high), bus (aes_inv_cipher_ctrl_if    |
// |               master: start/reuse_key in, busy/done/round/valid_* out,      |
// |               done_* in, error out when enabled).                           |
// | Options     : AES_INV_TIMEOUT_EN - per-step timeout into a sticky ERR state |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = 10,
  parameter int ROUND_W = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_cipher_ctrl_if.master bus
);

  localparam logic [ROUND_W-1:0] c_nr = ROUND_W'(NR);

  state_t               r_state;
  state_t               w_state_nx;
  logic [ROUND_W-1:0]   r_round;
  logic [ROUND_W-1:0]   w_round_nx;
  logic                 r_key_ok;
  logic                 w_key_ok_nx;

  logic [NUM_STEPS-1:0] w_done_in;
  logic [NUM_STEPS-1:0] w_cur_step;
  logic [NUM_STEPS-1:0] w_nx_step;
  logic [NUM_STEPS-1:0] w_set;
  logic [NUM_STEPS-1:0] w_clr;
  logic [NUM_STEPS-1:0] w_valid;
  logic                 w_step_done;

  assign w_done_in = {bus.done_invmix, bus.done_invsub, bus.done_invshift,
                      bus.done_ark, bus.done_keyexp};

  // Only the done belonging to the active step counts; strays are ignored.
  assign w_cur_step  = step_of(r_state);
  assign w_nx_step   = step_of(w_state_nx);
  assign w_step_done = |(w_cur_step & w_done_in);

`ifdef AES_INV_TIMEOUT_EN
  logic [NUM_STEPS-1:0] w_timeout;
  logic                 w_step_timeout;

  // A done arriving on the timeout cycle still wins.
  assign w_step_timeout = (|(w_cur_step & w_timeout)) && !w_step_done;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_round  <= '0;
      r_key_ok <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_round  <= w_round_nx;
      r_key_ok <= w_key_ok_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx  = r_state;
    w_round_nx  = r_round;
    w_key_ok_nx = r_key_ok;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          if (bus.reuse_key && r_key_ok) begin
            w_state_nx = ST_ARK_INIT;
            w_round_nx = c_nr;
          end else begin
            w_state_nx = ST_KEY_EXP;
          end
        end
      end
      ST_KEY_EXP: begin
        if (bus.done_keyexp) begin
          w_key_ok_nx = 1'b1;
          w_round_nx  = c_nr;
          w_state_nx  = ST_ARK_INIT;
        end
      end
      ST_ARK_INIT: begin
        if (bus.done_ark) begin
          w_round_nx = r_round - ROUND_W'(1);
          w_state_nx = ST_INV_SHIFT;
        end
      end
      ST_INV_SHIFT: begin
        if (bus.done_invshift) begin
          w_state_nx = ST_INV_SUB;
        end
      end
      ST_INV_SUB: begin
        if (bus.done_invsub) begin
          w_state_nx = ST_ARK;
        end
      end
      ST_ARK: begin
        // The final round has no InvMixColumns; round is never decremented
        // past 0 because ARK(0) leads straight to DONE.
        if (bus.done_ark) begin
          w_state_nx = (r_round != '0) ? ST_INV_MIX : ST_DONE;
        end
      end
      ST_INV_MIX: begin
        if (bus.done_invmix) begin
          w_round_nx = r_round - ROUND_W'(1);
          w_state_nx = ST_INV_SHIFT;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

`ifdef AES_INV_TIMEOUT_EN
    if (w_step_timeout) begin
      w_state_nx = ST_ERR;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Per-step valid registers. Consecutive states never share a step, so a
  // valid rises when the next state owns the step and the current one does
  // not, and falls whenever the next state does not own it (done, timeout,
  // or recovery from an illegal state).
  // ---------------------------------------------------------------------------
  assign w_set = w_nx_step & ~w_cur_step;
  assign w_clr = ~w_nx_step;

  for (genvar i = 0; i < NUM_STEPS; i++) begin : g_step
    aes_step_hs #(
      .TIMEOUT (TIMEOUT)
    ) u_hs (
      .clk     (clk),
      .rst     (rst),
      .set     (w_set[i]),
      .clr     (w_clr[i]),
`ifdef AES_INV_TIMEOUT_EN
      .timeout (w_timeout[i]),
`endif
      .valid   (w_valid[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.valid_keyexp   = w_valid[STEP_KEYEXP];
  assign bus.valid_ark      = w_valid[STEP_ARK];
  assign bus.valid_invshift = w_valid[STEP_INV_SHIFT];
  assign bus.valid_invsub   = w_valid[STEP_INV_SUB];
  assign bus.valid_invmix   = w_valid[STEP_INV_MIX];

  assign bus.round = r_round;
  assign bus.done  = (r_state == ST_DONE);
  assign bus.busy  = (r_state != ST_IDLE) && (r_state != ST_DONE) &&
                     (r_state != ST_ERR);
`ifdef AES_INV_TIMEOUT_EN
  assign bus.error = (r_state == ST_ERR);
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_aes_inv_cipher_ctrl                                        |
// | Description : Directed self-checking bench. Instance 0 uses NR=10,          |
// |               instance 1 uses NR=14. A negedge responder plays the         |
// |               datapath steps, logs completed handshakes and watches for     |
// |               valid overlap, early valid drop and round instability.        |
// |               Timeout scenario compiled only with AES_INV_TIMEOUT_EN.       |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_aes_inv_cipher_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Step bit order: 0 keyexp, 1 ark, 2 invshift, 3 invsub, 4 invmix
  localparam logic [4:0] V_KEY = 5'b00001;
  localparam logic [4:0] V_ARK = 5'b00010;
  localparam logic [4:0] V_SUB = 5'b01000;
  localparam logic [4:0] V_MIX = 5'b10000;

  logic       drv_rst     [2] = '{1'b0, 1'b0};
  logic       drv_start   [2] = '{1'b0, 1'b0};
  logic       drv_reuse   [2] = '{1'b0, 1'b0};
  logic       noise_start [2] = '{1'b0, 1'b0};
  logic [4:0] drv_done    [2] = '{5'd0, 5'd0};

  logic [4:0] mon_valid [2];
  logic [3:0] mon_round [2];
  logic       mon_busy  [2];
  logic       mon_done  [2];
  logic       mon_err   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int P_NR = (g == 0) ? 10 : 14;
    aes_inv_cipher_ctrl_if #(.ROUND_W(4)) bus ();

    assign bus.start         = drv_start[g] | noise_start[g];
    assign bus.reuse_key     = drv_reuse[g];
    assign bus.done_keyexp   = drv_done[g][0];
    assign bus.done_ark      = drv_done[g][1];
    assign bus.done_invshift = drv_done[g][2];
    assign bus.done_invsub   = drv_done[g][3];
    assign bus.done_invmix   = drv_done[g][4];
    assign mon_valid[g] = {bus.valid_invmix, bus.valid_invsub, bus.valid_invshift,
                           bus.valid_ark, bus.valid_keyexp};
    assign mon_round[g] = bus.round;
    assign mon_busy[g]  = bus.busy;
    assign mon_done[g]  = bus.done;
`ifdef AES_INV_TIMEOUT_EN
    assign mon_err[g]   = bus.error;
`else
    assign mon_err[g]   = 1'b0;
`endif

    aes_inv_cipher_ctrl #(.NR(P_NR), .ROUND_W(4), .TIMEOUT(64)) u_dut (
      .clk (clk),
      .rst (drv_rst[g]),
      .bus (bus)
    );
  end

  // Responder configuration (written only by the test tasks)
  bit         auto_en  [2] = '{1'b0, 1'b0};
  bit         noise_en [2] = '{1'b0, 1'b0};
  int         max_dly  [2] = '{0, 0};
  logic [4:0] withhold [2] = '{5'd0, 5'd0};
  int         clr_seq  [2] = '{0, 0};

  // Responder state and logs (written only by the responder)
  int         seen_seq [2] = '{0, 0};
  int         wcnt     [2];
  int         cur_dly  [2];
  int         step_cnt [2][5];
  int         ark_log  [2][40];
  int         ark_n    [2];
  int         viol_ovl [2];
  int         viol_hold[2];
  int         viol_rnd [2];
  logic [4:0] prev_v   [2];
  logic [4:0] prev_d   [2];
  logic [3:0] prev_r   [2];

  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) begin
    logic [4:0] v;
    logic [4:0] d;
    for (int i = 0; i < 2; i++) begin
      v = mon_valid[i];
      d = '0;
      if (seen_seq[i] != clr_seq[i]) begin
        seen_seq[i] = clr_seq[i];
        for (int k = 0; k < 5; k++) step_cnt[i][k] = 0;
        ark_n[i] = 0; viol_ovl[i] = 0; viol_hold[i] = 0; viol_rnd[i] = 0;
        wcnt[i] = 0; cur_dly[i] = 0; prev_v[i] = '0; prev_d[i] = '0;
      end
      if (!drv_rst[i]) begin
        if (mon_busy[i] ? ($countones(v) != 1) : (v != 5'd0)) viol_ovl[i]++;
        if ((prev_v[i] & ~v & ~prev_d[i]) != 5'd0) viol_hold[i]++;
        if (prev_v[i][1] && v[1] && (mon_round[i] != prev_r[i])) viol_rnd[i]++;
        if (auto_en[i] && (v != 5'd0) && ((v & withhold[i]) == 5'd0)) begin
          if (wcnt[i] >= cur_dly[i]) begin
            d = v;
            for (int k = 0; k < 5; k++) if (v[k]) step_cnt[i][k]++;
            if (v[1]) begin
              if (ark_n[i] < 40) ark_log[i][ark_n[i]] = int'(mon_round[i]);
              ark_n[i]++;
            end
            wcnt[i] = 0;
            cur_dly[i] = (max_dly[i] > 0) ? int'($urandom_range(0, max_dly[i])) : 0;
          end else begin
            wcnt[i]++;
          end
        end
        if (noise_en[i]) d = d | (5'($urandom) & ~v);
        noise_start[i] = noise_en[i] && mon_busy[i] && ($urandom_range(0, 3) == 0);
      end else begin
        noise_start[i] = 1'b0;
      end
      prev_v[i] = v;
      prev_d[i] = d;
      prev_r[i] = mon_round[i];
      drv_done[i] = d;
    end
  end

  // Start pulse: returns on the negedge after the accepting posedge.
  task automatic pulse_start(input int d, input logic reuse);
    @(negedge clk);
    drv_start[d] = 1'b1;
    drv_reuse[d] = reuse;
    @(negedge clk);
    drv_start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mon_done[d]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    drv_rst[0] = 1'b1;
    drv_rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (mon_valid[d] !== 5'd0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 00000", d, mon_valid[d]); end
      n_cmp++; if (mon_busy[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", d, mon_busy[d]); end
      n_cmp++; if (mon_done[d] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", d, mon_done[d]); end
      n_cmp++; if (mon_round[d] !== 4'd0) begin n_err++; $display("FAIL reset_round[%0d]: got %0d want 0", d, mon_round[d]); end
      n_cmp++; if (mon_err[d] !== 1'b0) begin n_err++; $display("FAIL reset_error[%0d]: got %b want 0", d, mon_err[d]); end
    end
    @(negedge clk);
    drv_rst[0] = 1'b0;
    drv_rst[1] = 1'b0;
  endtask

  task automatic test_full_decrypt();
    bit ok;
    bit seq_ok;
    auto_en[0] = 1'b1;
    clr_seq[0]++;
    pulse_start(0, 1'b0);
    n_cmp++; if (mon_valid[0] !== V_KEY) begin n_err++; $display("FAIL full_first_req: got %b want %b", mon_valid[0], V_KEY); end
    n_cmp++; if (mon_busy[0] !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", mon_busy[0]); end
    wait_done(0, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL full_wait_done: got timeout want done"); end
    n_cmp++; if (mon_busy[0] !== 1'b0) begin n_err++; $display("FAIL full_busy_in_done: got %b want 0", mon_busy[0]); end
    n_cmp++; if (step_cnt[0][0] != 1) begin n_err++; $display("FAIL full_keyexp_cnt: got %0d want 1", step_cnt[0][0]); end
    n_cmp++; if (step_cnt[0][1] != 11) begin n_err++; $display("FAIL full_ark_cnt: got %0d want 11", step_cnt[0][1]); end
    n_cmp++; if (step_cnt[0][2] != 10) begin n_err++; $display("FAIL full_shift_cnt: got %0d want 10", step_cnt[0][2]); end
    n_cmp++; if (step_cnt[0][3] != 10) begin n_err++; $display("FAIL full_sub_cnt: got %0d want 10", step_cnt[0][3]); end
    n_cmp++; if (step_cnt[0][4] != 9) begin n_err++; $display("FAIL full_mix_cnt: got %0d want 9", step_cnt[0][4]); end
    seq_ok = 1'b1;
    for (int j = 0; j <= 10; j++) if (ark_log[0][j] != 10 - j) seq_ok = 1'b0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL full_ark_rounds: got first=%0d last=%0d want 10..0", ark_log[0][0], ark_log[0][10]); end
    n_cmp++; if (viol_ovl[0] != 0) begin n_err++; $display("FAIL full_overlap: got %0d want 0", viol_ovl[0]); end
    n_cmp++; if (viol_hold[0] != 0) begin n_err++; $display("FAIL full_hold: got %0d want 0", viol_hold[0]); end
    n_cmp++; if (viol_rnd[0] != 0) begin n_err++; $display("FAIL full_round_stable: got %0d want 0", viol_rnd[0]); end
  endtask

  task automatic test_reuse_key();
    bit ok;
    clr_seq[0]++;
    pulse_start(0, 1'b1);
    n_cmp++; if (mon_valid[0] !== V_ARK) begin n_err++; $display("FAIL reuse_first_req: got %b want %b", mon_valid[0], V_ARK); end
    n_cmp++; if (mon_round[0] !== 4'd10) begin n_err++; $display("FAIL reuse_round: got %0d want 10", mon_round[0]); end
    n_cmp++; if (mon_done[0] !== 1'b0) begin n_err++; $display("FAIL reuse_done_clear: got %b want 0", mon_done[0]); end
    wait_done(0, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL reuse_wait_done: got timeout want done"); end
    n_cmp++; if (step_cnt[0][0] != 0) begin n_err++; $display("FAIL reuse_keyexp_cnt: got %0d want 0", step_cnt[0][0]); end
    n_cmp++; if (step_cnt[0][1] != 11) begin n_err++; $display("FAIL reuse_ark_cnt: got %0d want 11", step_cnt[0][1]); end
  endtask

  task automatic test_noise();
    bit ok;
    bit seq_ok;
    clr_seq[0]++;
    noise_en[0] = 1'b1;
    pulse_start(0, 1'b0);
    wait_done(0, 500, ok);
    noise_en[0] = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL noise_wait_done: got timeout want done"); end
    n_cmp++; if (step_cnt[0][0] != 1) begin n_err++; $display("FAIL noise_keyexp_cnt: got %0d want 1", step_cnt[0][0]); end
    n_cmp++; if (step_cnt[0][1] != 11) begin n_err++; $display("FAIL noise_ark_cnt: got %0d want 11", step_cnt[0][1]); end
    n_cmp++; if (step_cnt[0][2] != 10) begin n_err++; $display("FAIL noise_shift_cnt: got %0d want 10", step_cnt[0][2]); end
    n_cmp++; if (step_cnt[0][3] != 10) begin n_err++; $display("FAIL noise_sub_cnt: got %0d want 10", step_cnt[0][3]); end
    n_cmp++; if (step_cnt[0][4] != 9) begin n_err++; $display("FAIL noise_mix_cnt: got %0d want 9", step_cnt[0][4]); end
    seq_ok = (ark_n[0] == 11);
    for (int j = 0; j <= 10; j++) if (ark_log[0][j] != 10 - j) seq_ok = 1'b0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL noise_ark_rounds: got n=%0d want 11 rounds 10..0", ark_n[0]); end
    n_cmp++; if (viol_ovl[0] != 0) begin n_err++; $display("FAIL noise_overlap: got %0d want 0", viol_ovl[0]); end
    n_cmp++; if (viol_hold[0] != 0) begin n_err++; $display("FAIL noise_hold: got %0d want 0", viol_hold[0]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    clr_seq[0]++;
    pulse_start(0, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mon_valid[0] == V_MIX && mon_round[0] == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL midrst_reach_mix5: got not reached want INV_MIX at round 5"); end
    drv_rst[0] = 1'b1;
    #1;
    n_cmp++; if (mon_valid[0] !== 5'd0) begin n_err++; $display("FAIL midrst_valid: got %b want 00000", mon_valid[0]); end
    n_cmp++; if (mon_busy[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", mon_busy[0]); end
    n_cmp++; if (mon_round[0] !== 4'd0) begin n_err++; $display("FAIL midrst_round: got %0d want 0", mon_round[0]); end
    n_cmp++; if (mon_done[0] !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", mon_done[0]); end
    @(negedge clk);
    drv_rst[0] = 1'b0;
    clr_seq[0]++;
    pulse_start(0, 1'b1);
    n_cmp++; if (mon_valid[0] !== V_KEY) begin n_err++; $display("FAIL midrst_keyexp_again: got %b want %b", mon_valid[0], V_KEY); end
    wait_done(0, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_wait_done: got timeout want done"); end
  endtask

`ifdef AES_INV_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit found;
    clr_seq[0]++;
    withhold[0] = V_SUB;
    pulse_start(0, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (mon_valid[0] == V_SUB) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL tmo_reach_sub: got not reached want valid_invsub"); end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) begin
        n_cmp++; if (mon_err[0] !== 1'b0 || mon_valid[0] !== V_SUB) begin n_err++; $display("FAIL tmo_early: got err=%b valid=%b want err=0 valid=%b", mon_err[0], mon_valid[0], V_SUB); end
      end
    end
    n_cmp++; if (mon_err[0] !== 1'b1) begin n_err++; $display("FAIL tmo_error: got %b want 1", mon_err[0]); end
    n_cmp++; if (mon_valid[0] !== 5'd0) begin n_err++; $display("FAIL tmo_valid: got %b want 00000", mon_valid[0]); end
    n_cmp++; if (mon_busy[0] !== 1'b0) begin n_err++; $display("FAIL tmo_busy: got %b want 0", mon_busy[0]); end
    withhold[0] = 5'd0;
    pulse_start(0, 1'b1);
    n_cmp++; if (mon_err[0] !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", mon_err[0]); end
    n_cmp++; if (mon_valid[0] !== V_ARK) begin n_err++; $display("FAIL tmo_restart: got %b want %b", mon_valid[0], V_ARK); end
    wait_done(0, 500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_wait_done: got timeout want done"); end
  endtask
`endif

  task automatic test_nr14_random();
    bit ok;
    bit seq_ok;
    auto_en[1] = 1'b1;
    max_dly[1] = 20;
    clr_seq[1]++;
    pulse_start(1, 1'b0);
    n_cmp++; if (mon_valid[1] !== V_KEY) begin n_err++; $display("FAIL nr14_first_req: got %b want %b", mon_valid[1], V_KEY); end
    wait_done(1, 4000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL nr14_wait_done: got timeout want done"); end
    n_cmp++; if (step_cnt[1][1] != 15) begin n_err++; $display("FAIL nr14_ark_cnt: got %0d want 15", step_cnt[1][1]); end
    n_cmp++; if (step_cnt[1][4] != 13) begin n_err++; $display("FAIL nr14_mix_cnt: got %0d want 13", step_cnt[1][4]); end
    n_cmp++; if (step_cnt[1][2] != 14 || step_cnt[1][3] != 14) begin n_err++; $display("FAIL nr14_shift_sub_cnt: got %0d/%0d want 14/14", step_cnt[1][2], step_cnt[1][3]); end
    seq_ok = (ark_n[1] == 15);
    for (int j = 0; j <= 14; j++) if (ark_log[1][j] != 14 - j) seq_ok = 1'b0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL nr14_ark_rounds: got n=%0d want 15 rounds 14..0", ark_n[1]); end
    n_cmp++; if (viol_hold[1] != 0) begin n_err++; $display("FAIL nr14_hold: got %0d want 0", viol_hold[1]); end
    n_cmp++; if (viol_ovl[1] != 0) begin n_err++; $display("FAIL nr14_overlap: got %0d want 0", viol_ovl[1]); end
    n_cmp++; if (viol_rnd[1] != 0) begin n_err++; $display("FAIL nr14_round_stable: got %0d want 0", viol_rnd[1]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_decrypt();
    test_reuse_key();
    test_noise();
    test_reset_mid();
`ifdef AES_INV_TIMEOUT_EN
    test_timeout();
`endif
    test_nr14_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Top-level sequencer for AES decryption (inverse cipher); the decrypt-side counterpart of the encryption sequencer.
- Drives the inverse datapath steps over per-step valid/done handshakes: key expansion, AddRoundKey, InvShiftRows, InvSubBytes, InvMixColumns.
- Round index counts down from NR to 0.
- Control only; state data never passes through this block.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256)
- ROUND_W, 4, width of the round output
- TIMEOUT, 64, max cycles a step may take before error (used only with the optional feature)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin decryption; accepted only in IDLE or DONE
- reuse_key  input  1  sampled with start; skip key expansion if a key was already expanded since reset
- busy  output  1  high in every state except IDLE/DONE
- done  output  1  level; high in DONE until the next accepted start
- round  output  ROUND_W  round index presented to AddRoundKey
- valid_keyexp / valid_ark / valid_invshift / valid_invsub / valid_invmix  output  1 each  step request
- done_keyexp / done_ark / done_invshift / done_invsub / done_invmix  input  1 each  step completion pulse
- error  output  1  sticky timeout flag (optional feature only)

Behaviour:
- Reset: state IDLE; all valid_* 0; busy 0; done 0; round 0; key_ok (internal) 0; error 0.
- State encoding, 4 bits: IDLE, KEY_EXP, ARK_INIT, INV_SHIFT, INV_SUB, ARK, INV_MIX, DONE, ERR.
- Handshake:
  - valid_X rises on the clock edge that enters the state.
  - valid_X is held until done_X is sampled high.
  - On that same edge valid_X falls and the next step's valid rises. No idle cycle between steps.
  - A done_* input not matching the current state is ignored.
  - Exactly one valid_* is high at any time.
- Start: start high in IDLE or DONE at edge t gives, at t+1:
  - done 0, busy 1.
  - If reuse_key && key_ok: state ARK_INIT, valid_ark 1, round NR.
  - Otherwise: state KEY_EXP, valid_keyexp 1.
- start while busy is ignored.
- KEY_EXP: on done_keyexp, set key_ok 1, round NR, go to ARK_INIT.
- ARK_INIT: on done_ark, round <= round-1, go to INV_SHIFT.
- INV_SHIFT: on done_invshift, go to INV_SUB.
- INV_SUB: on done_invsub, go to ARK.
- ARK:
  - On done_ark with round != 0: go to INV_MIX.
  - On done_ark with round == 0: go to DONE (done 1, busy 0).
- INV_MIX: on done_invmix, round <= round-1, go to INV_SHIFT.
- Resulting sequence:
  - ARK(NR).
  - For each r = NR-1..1: InvShift, InvSub, ARK(r), InvMix.
  - Final round: InvShift, InvSub, ARK(0). No InvMix in the final round.
- round is stable whenever valid_ark is high. Never underflows.
- Totals per run: ARK NR+1; InvShift NR; InvSub NR; InvMix NR-1; keyexp 0 or 1.
- Reset mid-operation: immediate return to the reset values, including key_ok 0. A subsequent reuse_key start therefore performs key expansion.
- Unknown state: go to IDLE with all valid_* 0.

Optional Feature:
- Macro: AES_INV_TIMEOUT_EN.
- Defined:
  - Counter of cycles spent in the current step state, cleared on every state change.
  - Reaching TIMEOUT with no matching done: go to ERR, all valid_* 0, error 1, busy 0.
  - Exit ERR only on start, which clears error and follows the normal start rules.
- Undefined:
  - No counter, no ERR state; the block waits indefinitely.
  - error port is absent.

Decomposition:
- Package aes_pkg:
  - state enum / localparams.
  - NR constants for AES-128/192/256.
  - ROUND_W.
- Sub-module aes_step_hs: generic valid/done handshake register (set, clear-on-done, optional timeout counter). Instantiated once per step or once and muxed. The FSM stays in the top.

Test Plan:
- NR=10, all step stubs pulse done one cycle after valid, start, reuse_key=0 → 1 keyexp, ARK rounds 10,9,…,0 (11 total), 10 InvShift, 10 InvSub, 9 InvMix; done=1 after the ARK(0) done; busy low in DONE.
- Second start with reuse_key=1 → no valid_keyexp; first request is valid_ark with round=10 one cycle after start.
- Pulse start at random cycles during a run; pulse non-matching done_* inputs → sequence and counts identical to the first scenario; no valid overlap.
- Assert rst during INV_MIX at round 5 → all outputs 0 in the same cycle; then start with reuse_key=1 → valid_keyexp asserted.
- NR=14 with random 0–20-cycle done delays → 15 ARKs, 13 InvMix; each valid held until its done.
- With AES_INV_TIMEOUT_EN, TIMEOUT=64, withhold done_invsub → exactly 64 cycles later error=1 and valid_invsub=0; start clears error.
